rom_streamer: RTL and testbench
===============================

ROM_STREAMER -- requirements
Module: rom_streamer

Interface
REQ-001 The block SHALL have parameter N_ADDR_BITS, default 16, meaning ROM address MSB index; ROM depth = 2^(N_ADDR_BITS+1) bytes.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, begins a pass from address 0; honoured only in IDLE or DONE.
REQ-005 The block SHALL have port abort, input, 1, terminates any pass and returns to IDLE.
REQ-006 The block SHALL have port rom_addr, output, N_ADDR_BITS+1, registered ROM read address.
REQ-007 The block SHALL have port rom_data, input, 8, ROM byte; ROM updates it on clk falling edge.
REQ-008 The block SHALL have port rom_valid, input, 1, ROM flag; 1 means rom_data is non-null and in range.
REQ-009 The block SHALL have port out_data, output, 8, streamed byte, held stable while out_valid=1 and out_ready=0.
REQ-010 The block SHALL have port out_valid, output, 1, byte available to consumer.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts byte; a transfer is out_valid & out_ready on a rising edge.
REQ-012 The block SHALL have port busy, output, 1, high in FETCH or HOLD.
REQ-013 The block SHALL have port done, output, 1, high in DONE only.
REQ-014 The block SHALL have port byte_count, output, N_ADDR_BITS+2, bytes transferred in the current or last pass.

Function
REQ-015 The block SHALL implement FSM states IDLE, FETCH, HOLD, DONE.
REQ-016 The block SHALL, in IDLE or DONE with start=1 and abort=0, set rom_addr=0 and byte_count=0, and enter FETCH.
REQ-017 The block SHALL hold rom_addr constant for the whole FETCH cycle, so the ROM falling-edge read completes mid-cycle; rom_data/rom_valid are sampled at the rising edge ending FETCH.
REQ-018 The block SHALL, at the end of FETCH with rom_valid=1, load out_data<=rom_data, set out_valid=1, and enter HOLD.
REQ-019 The block SHALL, at the end of FETCH with rom_valid=0, leave out_valid=0 and enter DONE; the null terminator is never emitted.
REQ-020 The block SHALL, in HOLD with out_ready=1, clear out_valid, increment byte_count, and, if rom_addr = 2^(N_ADDR_BITS+1)-1, enter DONE; otherwise it SHALL increment rom_addr and enter FETCH.
REQ-021 The block SHALL remain in HOLD with all outputs unchanged while out_ready=0.
REQ-022 The block SHALL never wrap rom_addr to 0 within a pass.
REQ-023 The block SHALL present the first byte (out_valid=1) two rising edges after the edge that samples start.
REQ-024 The block SHALL sustain one byte per 2 cycles when out_ready is held at 1.
REQ-025 The block SHALL, when abort=1 in any state, enter IDLE, clear out_valid and rom_addr, and retain byte_count; abort has priority over start and over a simultaneous transfer, and an aborted HOLD byte is not counted.
REQ-026 The block SHALL ignore start in FETCH and HOLD.
REQ-027 The block SHALL not increment byte_count in any state other than HOLD.

Reset
REQ-028 The block SHALL, on rising edge with rst_n=0, enter IDLE with rom_addr=0, out_data=0, out_valid=0, busy=0, done=0, byte_count=0.
REQ-029 The block SHALL give rst_n=0 priority over start and abort, and SHALL allow it mid-pass with the same result.

Structure
REQ-030 The block SHALL take state encodings (IDLE=0, FETCH=1, HOLD=2, DONE=3) and the ROM_DEPTH derivation from shared package aoc_rom_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; the test bench SHALL instantiate the existing ROM model alongside it.

Verification
REQ-032 The bench SHALL load ROM with "L68\nR30\n" plus the ROM's appended "\n",0, pulse start, and hold out_ready=1 -> bytes L,6,8,\n,R,3,0,\n,\n in order, then done=1 and byte_count=9.
REQ-033 The bench SHALL sample start at edge t -> out_valid=1 at edge t+2 and rom_addr=0 during t+1.
REQ-034 The bench SHALL drive out_ready=0 for 5 cycles on the first byte -> out_data='L' stable and rom_addr=0 throughout, then 'L' transferred once.
REQ-035 The bench SHALL assert abort in HOLD on the third byte -> IDLE next edge, out_valid=0, byte_count=2; a subsequent start -> stream restarts at 'L'.
REQ-036 The bench SHALL use N_ADDR_BITS=2 with an 8-byte file and no null -> exactly 8 bytes emitted, done=1, rom_addr=7 (no wrap).
REQ-037 The bench SHALL drive rst_n=0 in FETCH -> IDLE with all outputs at reset values next edge.

Source files
------------

// File: rtl/aoc_rom_pkg.sv
// ---------------------------------------------------------------------------
// aoc_rom_pkg
// Shared definitions for the ROM streaming blocks.
//   state_t    : streamer FSM encoding (IDLE=0, FETCH=1, HOLD=2, DONE=3)
//   rom_depth(): ROM size in bytes for a given address MSB index
// ---------------------------------------------------------------------------
package aoc_rom_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ROM depth in bytes: the address bus is n_addr_bits+1 wide.
    function automatic longint unsigned rom_depth(input int n_addr_bits);
        return 64'd1 << (n_addr_bits + 1);
    endfunction

endpackage

// File: rtl/rom_streamer.sv
// ---------------------------------------------------------------------------
// rom_streamer
// Streams bytes from a falling-edge ROM, starting at address 0, until the ROM
// flags a null/out-of-range byte (rom_valid=0) or the last address has been
// transferred. One byte every two cycles with the consumer always ready.
//
// Ports
//   clk         : single clock, all state on rising edge
//   rst_n       : synchronous active-low reset
//   start       : begin a pass from address 0 (only in IDLE or DONE)
//   abort       : end any pass and return to IDLE
//   rom_addr    : registered ROM read address
//   rom_data    : ROM byte (ROM updates it on the falling edge)
//   rom_valid   : 1 = rom_data is non-null and in range
//   out_data    : streamed byte
//   out_valid   : byte available to consumer
//   out_ready   : consumer accepts byte
//   busy        : high in FETCH or HOLD
//   done        : high in DONE only
//   byte_count  : bytes transferred in the current or last pass
//   fsm_state   : current FSM state (debug visibility)
//
// Handshake: a byte transfers on a rising edge where out_valid=1 and
// out_ready=1. Once out_valid is raised, out_data stays unchanged until that
// transfer happens (or abort/reset drops out_valid). out_valid never depends
// combinationally on out_ready.
// ---------------------------------------------------------------------------
module rom_streamer
    import aoc_rom_pkg::*;
#(
    parameter int N_ADDR_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_ADDR_BITS:0]   rom_addr,
    input  logic [7:0]             rom_data,
    input  logic                   rom_valid,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic [N_ADDR_BITS+1:0] byte_count,
    output logic [1:0]             fsm_state
);

    localparam int ADDR_W = N_ADDR_BITS + 1;
    localparam int CNT_W  = N_ADDR_BITS + 2;
    localparam logic [N_ADDR_BITS:0] LAST_ADDR = ADDR_W'(rom_depth(N_ADDR_BITS) - 64'd1);

    state_t                  state, state_nxt;
    logic [N_ADDR_BITS:0]    addr_nxt;
    logic [7:0]              data_nxt;
    logic                    valid_nxt;
    logic [N_ADDR_BITS+1:0]  count_nxt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rom_addr   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            byte_count <= '0;
        end else begin
            state      <= state_nxt;
            rom_addr   <= addr_nxt;
            out_data   <= data_nxt;
            out_valid  <= valid_nxt;
            byte_count <= count_nxt;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        data_nxt  = out_data;
        valid_nxt = out_valid;
        count_nxt = byte_count;

        if (abort) begin
            // Abort wins over start and over a transfer in the same cycle;
            // byte_count is kept so the partial pass remains visible.
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            addr_nxt  = '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        addr_nxt  = '0;
                        count_nxt = '0;
                        state_nxt = FETCH;
                    end
                end
                FETCH: begin
                    // rom_addr was stable all cycle; the ROM's falling-edge
                    // read has settled by this rising edge.
                    if (rom_valid) begin
                        data_nxt  = rom_data;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = DONE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_nxt = 1'b0;
                        count_nxt = byte_count + CNT_W'(1);
                        // Stop at the top of the ROM rather than wrapping.
                        if (rom_addr == LAST_ADDR) begin
                            state_nxt = DONE;
                        end else begin
                            addr_nxt  = rom_addr + ADDR_W'(1);
                            state_nxt = FETCH;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy      = (state == FETCH) || (state == HOLD);
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_rom_streamer.sv
// ---------------------------------------------------------------------------
// tb_rom_streamer
// Bench for rom_streamer: a large-address instance (default N_ADDR_BITS) and a
// small one (N_ADDR_BITS=2), each with its own falling-edge ROM model.
// Expected streams come from a reference model (bytes from address 0 up to the
// first null or the end of the ROM) and are popped by negedge monitors.
// ---------------------------------------------------------------------------
module tb_rom_streamer;
    import aoc_rom_pkg::*;

    localparam int A_BITS = 16;
    localparam int B_BITS = 2;
    localparam int A_MEM  = 64;   // modelled part of the large ROM
    localparam int B_MEM  = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic              start_a, abort_a, out_ready_a;
    logic [A_BITS:0]   rom_addr_a;
    logic [7:0]        rom_data_a = '0;
    logic              rom_valid_a = 1'b0;
    logic [7:0]        out_data_a;
    logic              out_valid_a, busy_a, done_a;
    logic [A_BITS+1:0] byte_count_a;
    logic [1:0]        fsm_state_a;

    rom_streamer #(.N_ADDR_BITS(A_BITS)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .rom_valid(rom_valid_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .busy(busy_a), .done(done_a), .byte_count(byte_count_a),
        .fsm_state(fsm_state_a)
    );

    // ---------------- instance B ----------------
    logic              start_b, abort_b, out_ready_b;
    logic [B_BITS:0]   rom_addr_b;
    logic [7:0]        rom_data_b = '0;
    logic              rom_valid_b = 1'b0;
    logic [7:0]        out_data_b;
    logic              out_valid_b, busy_b, done_b;
    logic [B_BITS+1:0] byte_count_b;
    logic [1:0]        fsm_state_b;

    rom_streamer #(.N_ADDR_BITS(B_BITS)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .rom_valid(rom_valid_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .busy(busy_b), .done(done_b), .byte_count(byte_count_b),
        .fsm_state(fsm_state_b)
    );

    // ---------------- ROM models (falling-edge read) ----------------
    logic [7:0] rom_a [A_MEM];
    logic [7:0] rom_b [B_MEM];

    always @(negedge clk) begin
        if (rom_addr_a < A_MEM) begin
            rom_data_a  <= rom_a[rom_addr_a[5:0]];
            rom_valid_a <= (rom_a[rom_addr_a[5:0]] != 8'd0);
        end else begin
            rom_data_a  <= 8'd0;
            rom_valid_a <= 1'b0;
        end
        rom_data_b  <= rom_b[rom_addr_b];
        rom_valid_b <= (rom_b[rom_addr_b] != 8'd0);
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor A: transfer = valid & ready at the coming edge, unless aborted.
    logic       stall_a = 1'b0;
    logic [7:0] stall_data_a = '0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (stall_a && out_valid_a === 1'b1)
                chk("a_hold_stable", out_data_a, stall_data_a);
            if (out_valid_a === 1'b1 && out_ready_a && !abort_a) begin
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_extra_byte: got %0h expected none", out_data_a);
                end else begin
                    chk("a_stream", out_data_a, exp_a.pop_front());
                end
            end
            stall_a      = (out_valid_a === 1'b1) && !out_ready_a && !abort_a;
            stall_data_a = out_data_a;
        end else begin
            stall_a = 1'b0;
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid_b === 1'b1 && out_ready_b && !abort_b) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_extra_byte: got %0h expected none", out_data_b);
            end else begin
                chk("b_stream", out_data_b, exp_b.pop_front());
            end
        end
    end

    // ---------------- reference model ----------------
    // A pass emits bytes from address 0 up to (not including) the first null,
    // or up to the last ROM address.
    task automatic model_push_a(output int len);
        len = 0;
        while (len < A_MEM && rom_a[len] != 8'd0) begin
            exp_a.push_back(rom_a[len]);
            len++;
        end
    endtask

    task automatic model_push_b(output int len);
        len = 0;
        while (len < B_MEM && rom_b[len] != 8'd0) begin
            exp_b.push_back(rom_b[len]);
            len++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_text_a(input string s);
        foreach (rom_a[i]) rom_a[i] = 8'd0;
        for (int i = 0; i < s.len(); i++) rom_a[i] = s[i];
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_valid_a(input int budget);
        int n = 0;
        while (out_valid_a !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("a_valid_timeout", out_valid_a, 1);
    endtask

    // rnd: randomize out_ready and throw ignored start pulses while waiting
    task automatic wait_done_a(input int budget, input bit rnd);
        int n = 0;
        while (done_a !== 1'b1 && n < budget) begin
            if (rnd) begin
                out_ready_a = 1'($urandom_range(0, 1));
                start_a     = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
        start_a = 1'b0;
        chk("a_done_timeout", done_a, 1);
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_state"},  fsm_state_a, IDLE);
        chk({tag, "_addr"},   rom_addr_a, 0);
        chk({tag, "_data"},   out_data_a, 0);
        chk({tag, "_valid"},  out_valid_a, 0);
        chk({tag, "_busy"},   busy_a, 0);
        chk({tag, "_done"},   done_a, 0);
        chk({tag, "_count"},  byte_count_a, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int len;
        int n;
        rst_n = 1'b0;
        start_a = 0; abort_a = 0; out_ready_a = 0;
        start_b = 0; abort_b = 0; out_ready_b = 0;
        foreach (rom_a[i]) rom_a[i] = 8'd0;
        foreach (rom_b[i]) rom_b[i] = 8'd0;
        tick();
        tick();
        check_reset_a("rst_a");
        chk("rst_b_valid", out_valid_b, 0);
        chk("rst_b_count", byte_count_b, 0);
        rst_n = 1'b1;
        tick();

        // Text file with the ROM's appended newline and null.
        load_text_a("L68\nR30\n\n");
        model_push_a(len);
        chk("model_len", len, 9);
        out_ready_a = 1'b1;
        pulse_start_a();                  // edge t samples start
        chk("lat_addr_t1", rom_addr_a, 0);
        chk("lat_state_t1", fsm_state_a, FETCH);
        chk("lat_busy_t1", busy_a, 1);
        chk("lat_valid_t1", out_valid_a, 0);
        tick();                           // edge t+1
        chk("lat_valid_t2", out_valid_a, 1);
        chk("lat_data_t2", out_data_a, "L");
        wait_done_a(200, 1'b0);
        chk("text_done", done_a, 1);
        chk("text_count", byte_count_a, 9);
        chk("text_exp_empty", exp_a.size(), 0);

        // Backpressure on the first byte (restart from DONE).
        out_ready_a = 1'b0;
        model_push_a(len);
        pulse_start_a();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", out_data_a, "L");
            chk("bp_addr", rom_addr_a, 0);
            chk("bp_valid", out_valid_a, 1);
            chk("bp_count", byte_count_a, 0);
            tick();
        end
        out_ready_a = 1'b1;
        wait_done_a(200, 1'b0);
        chk("bp_count_end", byte_count_a, 9);
        chk("bp_exp_empty", exp_a.size(), 0);

        // Abort while holding the third byte, with a transfer attempted.
        out_ready_a = 1'b0;
        exp_a.push_back(rom_a[0]);
        exp_a.push_back(rom_a[1]);
        pulse_start_a();
        for (int k = 0; k < 2; k++) begin
            wait_valid_a(20);
            out_ready_a = 1'b1;
            tick();
            out_ready_a = 1'b0;
        end
        wait_valid_a(20);
        chk("abort_third_byte", out_data_a, "8");
        abort_a = 1'b1;
        out_ready_a = 1'b1;
        tick();
        abort_a = 1'b0;
        out_ready_a = 1'b0;
        chk("abort_state", fsm_state_a, IDLE);
        chk("abort_valid", out_valid_a, 0);
        chk("abort_addr", rom_addr_a, 0);
        chk("abort_count", byte_count_a, 2);
        chk("abort_busy", busy_a, 0);
        chk("abort_exp_empty", exp_a.size(), 0);
        tick();
        chk("abort_idle_count", byte_count_a, 2);
        out_ready_a = 1'b1;
        model_push_a(len);
        pulse_start_a();
        wait_done_a(200, 1'b0);
        chk("restart_count", byte_count_a, 9);
        chk("restart_exp_empty", exp_a.size(), 0);

        // Random files, random backpressure, ignored start pulses mid-pass.
        for (int p = 0; p < 8; p++) begin
            int l;
            l = (p == 0) ? 0 : $urandom_range(1, A_MEM - 4);
            foreach (rom_a[i]) rom_a[i] = 8'($urandom_range(1, 255));
            rom_a[l] = 8'd0;
            model_push_a(len);
            out_ready_a = 1'($urandom_range(0, 1));
            pulse_start_a();
            wait_done_a(2000, 1'b1);
            chk("rand_count", byte_count_a, l);
            chk("rand_exp_empty", exp_a.size(), 0);
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) tick();
        end

        // Small ROM completely filled: stops at the last address.
        for (int p = 0; p < 3; p++) begin
            foreach (rom_b[i]) rom_b[i] = 8'($urandom_range(1, 255));
            model_push_b(len);
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            n = 0;
            while (done_b !== 1'b1 && n < 500) begin
                out_ready_b = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            chk("b_done", done_b, 1);
            chk("b_count", byte_count_b, 8);
            chk("b_addr_last", rom_addr_b, 7);
            chk("b_exp_empty", exp_b.size(), 0);
            tick();
            chk("b_stay_done", done_b, 1);
            chk("b_addr_nowrap", rom_addr_b, 7);
        end

        // Reset in FETCH.
        load_text_a("L68\n");
        out_ready_a = 1'b1;
        pulse_start_a();
        chk("rstf_state", fsm_state_a, FETCH);
        rst_n = 1'b0;
        tick();
        check_reset_a("rstf");
        rst_n = 1'b1;
        tick();
        chk("rstf_exp_empty", exp_a.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
